seg7_scan: RTL and testbench

Multiplexed 4-digit display front end that sits directly upstream of the per-digit seven-segment decoder. It accepts a 14-bit binary value through a load handshake and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto a single 4-bit `bcd` bus, driving the decoder, with a one-hot digit-enable bus for the display anodes. Leading-zero blanking and an overflow indication are built in.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/bin2bcd.sv | 81 ++++++++
 rtl/seg7_scan.sv | 79 +++++++
 tb/tb_seg7_scan.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and FSM encoding for the multiplexed 4-digit display front end.
package seg7_pkg;
    localparam int unsigned DIGITS    = 4;
    localparam int unsigned VALUE_W   = 14;
    localparam int unsigned BCD_W     = 4 * DIGITS;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MAX_VALUE = 9999;
    localparam logic [3:0]  BCD_DASH  = 4'hA;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;
endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: one result bit per cycle, VALUE_W cycles per conversion.
module bin2bcd
    import seg7_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic               ovf,
    output logic               commit_c,
    output logic [BCD_W-1:0]   result_c
);

    state_t             state, state_next;
    logic [VALUE_W-1:0] shreg, shreg_next;
    logic [BCD_W-1:0]   acc, acc_next, acc_adj;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               ovf_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
            busy  <= (state_next == CONV);
        end
    end

    // Add-3 correction on every nibble that would overflow past 9 after the shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;
        commit_c   = 1'b0;
        result_c   = {acc_adj[BCD_W-2:0], shreg[VALUE_W-1]};
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = CONV;
                    shreg_next = value;
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = (32'(value) > MAX_VALUE);
                end
            end
            CONV: begin
                acc_next   = result_c;
                shreg_next = {shreg[VALUE_W-2:0], 1'b0};
                cnt_next   = cnt + CNT_W'(1);
                // Last bit shifted in: result_c is final and the display takes it this edge.
                if (cnt == CNT_W'(VALUE_W - 1)) begin
                    state_next = IDLE;
                    commit_c   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Display front end: converts a loaded binary value to BCD and scans the digits onto one bus.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    output logic               busy,
    output logic [3:0]         bcd,
    output logic [DIGITS-1:0]  an
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = $clog2(DIGITS);

    logic [DIGITS-1:0][3:0] digit;
    logic [DIV_W-1:0]       div;
    logic [IDX_W-1:0]       idx;
    logic                   commit_c;
    logic                   ovf;
    logic [BCD_W-1:0]       result_c;
    logic                   lit_c;

    bin2bcd u_bin2bcd (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .busy     (busy),
        .ovf      (ovf),
        .commit_c (commit_c),
        .result_c (result_c)
    );

    // Display digits change only on a completed conversion, all at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (commit_c) begin
            digit <= ovf ? {DIGITS{BCD_DASH}} : result_c;
        end
    end

    // Free-running scan, independent of the converter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_W'(SCAN_DIV - 1)) begin
            div <= '0;
            idx <= idx + IDX_W'(1);
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // A digit is lit if it or any more significant digit is non-zero.
    always_comb begin
        lit_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IDX_W'(i) >= idx && digit[i] != 4'd0) begin
                lit_c = 1'b1;
            end
        end
    end

    always_comb begin
        bcd = digit[idx];
        an  = DIGITS'(1) << idx;
        if (LZ_BLANK && idx != '0 && !lit_c) begin
            an = '0;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with a cycle-level reference model of display contents and scan.
module tb_seg7_scan;

    localparam int SD = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic [13:0] value = '0;
    logic        busy;
    logic [3:0]  bcd;
    logic [3:0]  an;

    always #5 clk = ~clk;

    seg7_scan #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .load  (load),
        .busy  (busy),
        .bcd   (bcd),
        .an    (an)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: cycles since reset, conversion countdown, value on display.
    int m_scan = 0;
    int m_left = 0;
    int m_pend = 0;
    int m_disp = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_scan = 0;
            m_left = 0;
            m_pend = 0;
            m_disp = 0;
        end else begin
            m_scan++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_disp = m_pend;
            end else if (load) begin
                m_left = 14;
                m_pend = int'(value);
            end
        end
    end

    function automatic int pow10(input int n);
        int p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    function automatic int exp_digit(input int v, input int i);
        if (v > 9999) return 10;
        return (v / pow10(i)) % 10;
    endfunction

    function automatic int exp_an(input int v, input int i);
        if (i != 0 && v <= 9999 && v < pow10(i)) return 0;
        return 1 << i;
    endfunction

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_left > 0));
        chk("bcd", int'(bcd), exp_digit(m_disp, (m_scan / SD) % 4));
        chk("an", int'(an), exp_an(m_disp, (m_scan / SD) % 4));
    end

    task automatic do_load(input int v);
        @(posedge clk);
        #1 load = 1'b1;
        value = 14'(v);
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    // Counts busy cycles after a load; optionally pulses a second load at negedge pulse_at.
    task automatic measure_busy(input int exp, input int pulse_at, input int pv);
        int n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == pulse_at) begin
                load  = 1'b1;
                value = 14'(pv);
            end else begin
                load = 1'b0;
            end
            if (busy) n++;
            else break;
        end
        load = 1'b0;
        chk("busy_len", n, exp);
    endtask

    // Literal slot expectations: nibble s of eb/ea is bcd/an for scan slot s.
    task automatic check_slots(input string tag, input logic [15:0] eb, input logic [15:0] ea);
        bit found = 1'b0;
        for (int k = 0; k < 4 * SD + 2; k++) begin
            @(posedge clk);
            #1;
            if (m_scan % (4 * SD) == 0) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_sync"}, int'(found), 1);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk({tag, "_bcd"}, int'(bcd), int'(eb[4*s +: 4]));
            chk({tag, "_an"}, int'(an), int'(ea[4*s +: 4]));
            repeat (SD) @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_an", int'(an), 1);
        chk("rst_bcd", int'(bcd), 0);
        chk("rst_busy", int'(busy), 0);

        do_load(1234);
        measure_busy(14, 0, 0);
        check_slots("d1234", 16'h1234, 16'h8421);
        check_slots("d1234r", 16'h1234, 16'h8421);

        do_load(7);
        measure_busy(14, 0, 0);
        check_slots("d7", 16'h0007, 16'h0001);

        do_load(0);
        measure_busy(14, 0, 0);
        check_slots("d0", 16'h0000, 16'h0001);

        do_load(10000);
        measure_busy(14, 0, 0);
        check_slots("ovf10000", 16'hAAAA, 16'h8421);

        do_load(16383);
        measure_busy(14, 0, 0);
        check_slots("ovf16383", 16'hAAAA, 16'h8421);

        do_load(9999);
        measure_busy(14, 0, 0);
        check_slots("d9999", 16'h9999, 16'h8421);

        do_load(42);
        measure_busy(14, 5, 99);
        check_slots("d42", 16'h0042, 16'h0021);

        do_load(5678);
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_an", int'(an), 1);
        chk("arst_bcd", int'(bcd), 0);
        chk("arst_busy", int'(busy), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_slots("abort", 16'h0000, 16'h0001);
        repeat (20) @(posedge clk);
        check_slots("abort2", 16'h0000, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
